// File: rtl/inst_fetch_unit.sv
// Fetch stage: samples the PC, reads instruction memory over a req/ack handshake and
// presents the instruction to decode under valid/ready, pulsing pcWrite once it is taken.
module inst_fetch_unit #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [ADDR_W-1:0] pcCur,
    input  logic              flush,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memData,
    output logic [DATA_W-1:0] instOut,
    output logic [ADDR_W-1:0] instPC,
    output logic              instValid,
    input  logic              instReady,
    output logic              pcWrite,
    output logic              fetchErr,
    output logic [1:0]        errCode
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    localparam logic [1:0] ErrMisaligned = 2'b01;
    localparam logic [1:0] ErrTimeout    = 2'b10;

    typedef enum logic [2:0] {
        StSample,
        StReq,
        StHold,
        StAdvance,
        StDrop,
        StErr
    } stateT;

    stateT           state;
    logic [CntW-1:0] waitCount;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= StSample;
            waitCount <= '0;
            memReq    <= 1'b0;
            memAddr   <= '0;
            instOut   <= '0;
            instPC    <= '0;
            instValid <= 1'b0;
            pcWrite   <= 1'b0;
            fetchErr  <= 1'b0;
            errCode   <= 2'b00;
        end else begin
            pcWrite <= 1'b0;
            case (state)
                StSample: begin
                    memAddr   <= pcCur;
                    waitCount <= '0;
                    if (pcCur[0]) begin
                        fetchErr <= 1'b1;
                        errCode  <= ErrMisaligned;
                        state    <= StErr;
                    end else begin
                        memReq <= 1'b1;
                        state  <= StReq;
                    end
                end
                // DROP shares REQ's ack/timeout handling; it only differs in discarding data.
                StReq, StDrop: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        if (state == StReq && !flush) begin
                            instOut   <= memData;
                            instPC    <= memAddr;
                            instValid <= 1'b1;
                            state     <= StHold;
                        end else begin
                            state <= StSample;
                        end
                    end else if (waitCount == CntMax) begin
                        memReq   <= 1'b0;
                        fetchErr <= 1'b1;
                        errCode  <= ErrTimeout;
                        state    <= StErr;
                    end else begin
                        // A raised request stays up until acked, so a flush only marks it stale.
                        waitCount <= waitCount + 1'b1;
                        if (flush) begin
                            state <= StDrop;
                        end
                    end
                end
                StHold: begin
                    if (flush) begin
                        instValid <= 1'b0;
                        state     <= StSample;
                    end else if (instReady) begin
                        instValid <= 1'b0;
                        pcWrite   <= 1'b1;
                        state     <= StAdvance;
                    end
                end
                StAdvance: begin
                    state <= StSample;
                end
                StErr: begin
                    memReq    <= 1'b0;
                    instValid <= 1'b0;
                end
                default: begin
                    state <= StSample;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: stimulus pushes expected instructions into a queue,
// a monitor pops and compares each presented instruction and checks pcWrite pulses.
module tb_inst_fetch_unit;

    logic        clock;
    logic        resetN;
    logic [15:0] pcCur;
    logic        flush;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [15:0] memData;
    logic [15:0] instOut;
    logic [15:0] instPC;
    logic        instValid;
    logic        instReady;
    logic        pcWrite;
    logic        fetchErr;
    logic [1:0]  errCode;

    inst_fetch_unit #(
        .ADDR_W (16),
        .DATA_W (16),
        .TIMEOUT(8)
    ) dut (
        .clock    (clock),
        .resetN   (resetN),
        .pcCur    (pcCur),
        .flush    (flush),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memAck   (memAck),
        .memData  (memData),
        .instOut  (instOut),
        .instPC   (instPC),
        .instValid(instValid),
        .instReady(instReady),
        .pcWrite  (pcWrite),
        .fetchErr (fetchErr),
        .errCode  (errCode)
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] pc;
    } expT;

    expT expQ[$];
    int  nChecks = 0;
    int  nFails  = 0;
    int  pwCount = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; the PC register model loads pc+2 at an edge where pcWrite was high.
    task automatic cyc();
        logic pw;
        pw = pcWrite;
        @(posedge clock);
        #1;
        if (pw) pcCur = pcCur + 16'd2;
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!memReq && n < 20) begin
            cyc();
            n++;
        end
        check(name, {31'd0, memReq}, 32'd1);
    endtask

    task automatic pushExp(input logic [15:0] data, input logic [15:0] pc);
        expT e;
        e.data = data;
        e.pc   = pc;
        expQ.push_back(e);
    endtask

    // Monitor: compare each newly presented instruction, and require pcWrite exactly
    // one cycle after an accepted (valid & ready & !flush) handshake.
    logic seen  = 1'b0;
    logic expPw = 1'b0;
    always @(negedge clock) begin
        if (!resetN) begin
            seen  = 1'b0;
            expPw = 1'b0;
        end else begin
            check("pcWrite", {31'd0, pcWrite}, {31'd0, expPw});
            if (pcWrite) pwCount++;
            expPw = instValid && instReady && !flush;
            if (instValid && !seen) begin
                seen = 1'b1;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected instruction: got instOut=0x%0h instPC=0x%0h required none",
                             instOut, instPC);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    check("instOut", {16'd0, instOut}, {16'd0, e.data});
                    check("instPC", {16'd0, instPC}, {16'd0, e.pc});
                end
            end else if (!instValid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int pw0;
        resetN    = 1'b0;
        pcCur     = 16'h0010;
        flush     = 1'b0;
        memAck    = 1'b0;
        memData   = 16'h0000;
        instReady = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst memReq", {31'd0, memReq}, 32'd0);
        check("rst memAddr", {16'd0, memAddr}, 32'd0);
        check("rst instOut", {16'd0, instOut}, 32'd0);
        check("rst instPC", {16'd0, instPC}, 32'd0);
        check("rst instValid", {31'd0, instValid}, 32'd0);
        check("rst pcWrite", {31'd0, pcWrite}, 32'd0);
        check("rst fetchErr", {31'd0, fetchErr}, 32'd0);
        check("rst errCode", {30'd0, errCode}, 32'd0);

        // Basic fetch with ack one cycle after the request.
        resetN = 1'b1;
        pushExp(16'hA5C3, 16'h0010);
        waitReq("basic memReq");
        check("basic memAddr", {16'd0, memAddr}, 32'h0010);
        cyc();
        memAck  = 1'b1;
        memData = 16'hA5C3;
        cyc();
        memAck = 1'b0;
        check("basic instValid", {31'd0, instValid}, 32'd1);
        waitReq("next memReq");
        check("pcWrite pulses", pwCount, 32'd1);
        check("next memAddr", {16'd0, memAddr}, 32'h0012);

        // Back-pressure: decode stalls for 5 cycles.
        instReady = 1'b0;
        pushExp(16'h1234, 16'h0012);
        memAck  = 1'b1;
        memData = 16'h1234;
        cyc();
        memAck  = 1'b0;
        memData = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("bp instValid", {31'd0, instValid}, 32'd1);
            check("bp instOut", {16'd0, instOut}, 32'h1234);
            check("bp pcWrite", {31'd0, pcWrite}, 32'd0);
            cyc();
        end
        pw0       = pwCount;
        instReady = 1'b1;
        repeat (4) cyc();
        check("bp one pcWrite", pwCount, pw0 + 1);

        // Flush while the request is outstanding; ack arrives 3 cycles later.
        check("flush memAddr", {16'd0, memAddr}, 32'h0014);
        flush = 1'b1;
        pcCur = 16'h0200;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drop memReq held", {31'd0, memReq}, 32'd1);
            cyc();
        end
        memAck  = 1'b1;
        memData = 16'hDEAD;
        cyc();
        memAck = 1'b0;
        check("drop memReq low", {31'd0, memReq}, 32'd0);
        check("drop instValid", {31'd0, instValid}, 32'd0);
        waitReq("redirect memReq");
        check("redirect memAddr", {16'd0, memAddr}, 32'h0200);

        // Flush and accept in the same HOLD cycle: flush wins.
        instReady = 1'b0;
        pushExp(16'hBEEF, 16'h0200);
        memAck  = 1'b1;
        memData = 16'hBEEF;
        cyc();
        memAck = 1'b0;
        check("fva instValid", {31'd0, instValid}, 32'd1);
        flush     = 1'b1;
        instReady = 1'b1;
        cyc();
        flush     = 1'b0;
        instReady = 1'b0;
        check("fva instValid low", {31'd0, instValid}, 32'd0);
        check("fva pcWrite", {31'd0, pcWrite}, 32'd0);
        waitReq("refetch memReq");
        check("refetch memAddr", {16'd0, memAddr}, 32'h0200);
        pushExp(16'h0F0E, 16'h0200);
        instReady = 1'b1;
        memAck    = 1'b1;
        memData   = 16'h0F0E;
        cyc();
        memAck = 1'b0;

        // Timeout: no ack, memReq must fall after exactly 8 cycles.
        waitReq("timeout memReq");
        check("timeout memAddr", {16'd0, memAddr}, 32'h0202);
        n = 0;
        while (memReq && n < 20) begin
            n++;
            cyc();
        end
        check("timeout req cycles", n, 32'd8);
        check("timeout fetchErr", {31'd0, fetchErr}, 32'd1);
        check("timeout errCode", {30'd0, errCode}, 32'd2);
        repeat (3) cyc();
        check("timeout sticky", {30'd0, errCode}, 32'd2);
        check("timeout err memReq", {31'd0, memReq}, 32'd0);

        // Fresh run, then asynchronous reset in the middle of a request.
        resetN = 1'b0;
        cyc();
        check("reset clears err", {31'd0, fetchErr}, 32'd0);
        pcCur  = 16'h0300;
        resetN = 1'b1;
        waitReq("fresh memReq");
        check("fresh memAddr", {16'd0, memAddr}, 32'h0300);
        cyc();
        #2;
        resetN = 1'b0;
        #1;
        check("async rst memReq", {31'd0, memReq}, 32'd0);
        check("async rst memAddr", {16'd0, memAddr}, 32'd0);
        cyc();

        // Misaligned PC: no request, sticky error until reset.
        pcCur  = 16'h0013;
        resetN = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (memReq) n++;
            cyc();
        end
        check("mis no memReq", n, 32'd0);
        check("mis fetchErr", {31'd0, fetchErr}, 32'd1);
        check("mis errCode", {30'd0, errCode}, 32'd1);
        repeat (5) cyc();
        check("mis sticky", {30'd0, errCode}, 32'd1);
        check("mis instValid", {31'd0, instValid}, 32'd0);
        resetN = 1'b0;
        #1;
        check("mis rst fetchErr", {31'd0, fetchErr}, 32'd0);
        check("mis rst errCode", {30'd0, errCode}, 32'd0);

        check("queue drained", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Fetch-side responder to the PC register. Samples the current PC, runs a request/acknowledge read to instruction memory, and holds the returned 16-bit instruction for decode under a valid/ready handshake. Pulses pcWrite to advance the PC only after decode accepts the instruction. Handles redirect flushes, misaligned PCs and memory timeouts.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, instruction width
TIMEOUT, 64, max cycles memReq may wait for memAck before error (>=2)

Ports:
clock  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
pcCur  input  ADDR_W  current PC from PC register
flush  input  1  one-cycle pulse: PC redirected, discard current fetch
memReq  output  1  memory read request
memAddr  output  ADDR_W  read address, stable while memReq=1
memAck  input  1  one-cycle pulse: memData valid this cycle
memData  input  DATA_W  read data
instOut  output  DATA_W  fetched instruction
instPC  output  ADDR_W  address instOut was fetched from
instValid  output  1  instOut valid for decode
instReady  input  1  decode accepts instOut
pcWrite  output  1  one-cycle pulse enabling PC update
fetchErr  output  1  sticky error flag
errCode  output  2  01 misaligned PC, 10 memory timeout, 00 none

Behaviour:
- resetN=0 (async): state=SAMPLE, all outputs 0, timeout counter 0. Reset mid-transaction drops memReq immediately. No in-flight ack is tracked across reset.
- States: SAMPLE, REQ, HOLD, ADVANCE, DROP, ERR. All outputs are registered.
- SAMPLE: latch memAddr<=pcCur.
  - If pcCur[0]=1: go to ERR with fetchErr=1, errCode=01.
  - Otherwise: go to REQ with memReq=1 on the next cycle and counter cleared.
- REQ: memReq=1, memAddr held.
  - memAck=1: instOut<=memData, instPC<=memAddr, instValid<=1, memReq<=0, go HOLD. Minimum latency from SAMPLE to instValid is 2 cycles with a same-cycle ack.
  - Otherwise counter increments. When counter reaches TIMEOUT-1 without ack: memReq<=0, fetchErr=1, errCode=10, go ERR.
  - flush=1 without memAck: go DROP. memReq stays 1, because a request, once raised, must be held until it is acked.
  - flush=1 with memAck in the same cycle: data discarded, memReq<=0, go SAMPLE.
- DROP: memReq=1 and the counter keeps running.
  - On memAck: discard data, memReq<=0, go SAMPLE. Further flush pulses are ignored.
  - Timeout applies exactly as in REQ.
- HOLD: instValid=1; instOut and instPC held stable.
  - instReady=1 and flush=0: instValid<=0, pcWrite<=1 for exactly one cycle, go ADVANCE.
  - flush=1, with or without instReady: instValid<=0, no pcWrite, go SAMPLE. Flush wins.
- ADVANCE: pcWrite returns to 0 and the PC register loads its new value at this edge; go SAMPLE. This guarantees SAMPLE sees the updated pcCur.
- flush in SAMPLE or ADVANCE: no effect beyond the normal path. SAMPLE re-reads pcCur anyway.
- ERR: memReq=0, instValid=0, pcWrite=0. Held until resetN=0. fetchErr and errCode are sticky.
- pcWrite is never asserted except in the cycle after an accepted HOLD handshake. Throughput is at most one instruction per 4 cycles.
- Counter width is clog2(TIMEOUT). It saturates and never wraps.
- memAck outside REQ/DROP is ignored.

Test Plan:
- Basic fetch: reset, pcCur=0x0010, memAck one cycle after memReq with memData=0xA5C3, instReady=1 -> instValid with instOut=0xA5C3 and instPC=0x0010; one pcWrite pulse; the next memAddr equals the updated pcCur=0x0012.
- Back-pressure: instReady held 0 for 5 cycles in HOLD -> instOut stable, no pcWrite. instReady=1 -> exactly one pcWrite pulse.
- Flush in flight: flush during REQ with ack 3 cycles later carrying 0xDEAD, pcCur changed to 0x0200 -> memReq held until ack; 0xDEAD never presented; next memAddr=0x0200.
- Flush vs accept: flush and instReady in the same HOLD cycle -> instValid drops, no pcWrite, refetch at current pcCur.
- Misaligned: pcCur=0x0013 at SAMPLE -> no memReq, fetchErr=1, errCode=01, held until resetN low.
- Timeout and reset: TIMEOUT=8, no memAck -> memReq falls after 8 cycles, errCode=10. Then assert resetN=0 mid-REQ in a fresh run -> memReq=0 asynchronously before the next clock edge.
